beam_trigger_scaler: RTL and testbench
======================================

BEAM_TRIGGER_SCALER -- requirements
Module: beam_trigger_scaler

Interface
REQ-001 Parameter NBEAMS, default 2, number of beam trigger bits consumed (bit 0 = beam A, bit 1 = beam B of one dual beam DSP).
REQ-002 Parameter SCAL_BITS, default 16, width of each per-beam scaler.
REQ-003 Parameter HOLDOFF, default 4, dead-time cycles after an accepted trigger; legal range 0-255.
REQ-004 clk_i  input  1  single clock, same domain as the beam DSP outputs.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 trigger_i  input  NBEAMS  level trigger bits from the beam threshold DSP; 1 = over threshold.
REQ-007 period_i  input  1  one-cycle pulse closing the current scaler period.
REQ-008 trig_o  output  NBEAMS  one-cycle pulse per accepted trigger, per beam.
REQ-009 scal_valid_o  output  1  readout word valid.
REQ-010 scal_ready_i  input  1  readout consumer ready.
REQ-011 scal_data_o  output  SCAL_BITS  latched scaler value for beam scal_idx_o.
REQ-012 scal_idx_o  output  clog2(NBEAMS) (min 1)  beam index of scal_data_o.
REQ-013 overrun_o  output  1  sticky flag: a period closed while the previous dump was still in progress.

Function
REQ-014 A beam trigger is accepted in cycle n when trigger_i[b]=1 and that beam's holdoff counter is 0 in cycle n.
REQ-015 On acceptance, the holdoff counter loads HOLDOFF and decrements once per cycle to 0; trigger_i[b] is ignored while the counter is nonzero.
REQ-016 With HOLDOFF=0, every cycle with trigger_i[b]=1 is accepted.
REQ-017 trig_o[b] is registered: an acceptance in cycle n gives trig_o[b]=1 in cycle n+1 only.
REQ-018 Each accepted trigger increments that beam's live scaler by 1; the scaler saturates at 2^SCAL_BITS-1 and does not wrap.
REQ-019 On period_i=1 in IDLE: all live scalers copy to the shadow registers and clear to 0; an acceptance in the same cycle counts as 1 in the new period.
REQ-020 Readout FSM states: IDLE and DUMP.
REQ-021 IDLE->DUMP in the cycle after period_i; index = 0, scal_valid_o = 1.
REQ-022 In DUMP, scal_data_o = shadow[index]. A transfer occurs when scal_valid_o & scal_ready_i; index then increments.
REQ-023 A transfer at index NBEAMS-1 returns the FSM to IDLE with scal_valid_o=0 in the next cycle.
REQ-024 scal_data_o and scal_idx_o are held stable while scal_valid_o=1 and scal_ready_i=0.
REQ-025 period_i during DUMP: live scalers still clear (REQ-019); the shadow registers are NOT overwritten; the dump continues; overrun_o is set.
REQ-026 period_i in the same cycle as the final DUMP transfer is treated as period_i in DUMP (REQ-025).
REQ-027 overrun_o clears only on reset.

Reset
REQ-028 While rst_i=1: trig_o=0, scal_valid_o=0, scal_data_o=0, scal_idx_o=0, overrun_o=0; holdoff counters, live scalers and shadow registers are 0; FSM is in IDLE.
REQ-029 Reset asserted mid-DUMP abandons the dump; no further words are presented until the next period_i after reset.
REQ-030 Triggers and period_i present during the reset cycle are ignored.

Structure
REQ-031 The readout FSM state enum and the default SCAL_BITS/HOLDOFF constants are defined in a shared package, beam_trig_pkg.
REQ-032 The per-beam holdoff counter, acceptance logic and saturating scaler form one sub-module, beam_holdoff_counter, instantiated NBEAMS times by a generate loop.
REQ-033 The block contains no DSP primitives; all logic is fabric.

Verification
REQ-034 HOLDOFF=4, trigger_i[0] held high for 12 cycles -> trig_o[0] pulses at cycles 1, 6 and 11 after the first high cycle; scaler = 3.
REQ-035 HOLDOFF=0, trigger_i=2'b11 for 5 cycles, then period_i, scal_ready_i=1 -> words (idx0, 5) then (idx1, 5); scal_valid_o low on the following cycle.
REQ-036 SCAL_BITS=4, HOLDOFF=0, trigger_i[1] high for 20 cycles, then period_i -> idx1 word = 15 (saturated).
REQ-037 period_i, scal_ready_i=0 for 10 cycles, second period_i during that stall -> data/idx stable, first-period values delivered, overrun_o=1, live scalers cleared.
REQ-038 period_i coincident with an acceptance on beam 0 -> shadow excludes that trigger; next period reports 1 for beam 0.
REQ-039 rst_i pulsed after the first of two dump transfers -> scal_valid_o=0 the next cycle; all outputs 0; no further words until the next period_i.

Source files
------------

// File: rtl/beam_trig_pkg.sv
// beam_trig_pkg: readout state type and default constants shared by the beam trigger scaler
package beam_trig_pkg;
  typedef enum logic {IDLE = 1'b0, DUMP = 1'b1} rd_state_e;
  localparam int DEF_NBEAMS = 2;
  localparam int DEF_SCAL_BITS = 16;
  localparam int DEF_HOLDOFF = 4;
  function automatic int idx_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/beam_trigger_scaler_if.sv
// beam_trigger_scaler_if: scaler readout valid/ready word bus
interface beam_trigger_scaler_if
  import beam_trig_pkg::*;
#(
  parameter int SCAL_BITS = DEF_SCAL_BITS,
  parameter int IW = idx_bits(DEF_NBEAMS)
);
  logic scal_valid_o;
  logic scal_ready_i;
  logic [SCAL_BITS-1:0] scal_data_o;
  logic [IW-1:0] scal_idx_o;
  modport master(output scal_valid_o, scal_data_o, scal_idx_o, input scal_ready_i);
  modport slave(input scal_valid_o, scal_data_o, scal_idx_o, output scal_ready_i);
endinterface

// File: rtl/beam_holdoff_counter.sv
// beam_holdoff_counter: per-beam trigger acceptance with holdoff dead time and saturating scaler
module beam_holdoff_counter
  import beam_trig_pkg::*;
#(
  parameter int SCAL_BITS = DEF_SCAL_BITS,
  parameter int HOLDOFF = DEF_HOLDOFF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 trigger_i,
  input  logic                 clear_i,
  output logic                 trig_o,
  output logic [SCAL_BITS-1:0] count_o
);
  logic [7:0] hold_q, hold_d;
  logic [SCAL_BITS-1:0] cnt_q, cnt_d;
  logic trig_q, trig_d, accept;
  always_comb begin
    accept = trigger_i && hold_q == 8'd0;
    trig_d = accept;
    hold_d = accept ? 8'(HOLDOFF) : hold_q - {7'd0, hold_q != 8'd0};
    cnt_d = clear_i ? SCAL_BITS'(accept) : cnt_q + SCAL_BITS'(accept && cnt_q != '1);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= '0;
      cnt_q <= '0;
      trig_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      cnt_q <= cnt_d;
      trig_q <= trig_d;
    end
  end
  assign trig_o = trig_q;
  assign count_o = cnt_q;
endmodule

// File: rtl/beam_trigger_scaler.sv
// beam_trigger_scaler: per-beam trigger holdoff, scalers, and period-based shadow readout
module beam_trigger_scaler
  import beam_trig_pkg::*;
#(
  parameter int NBEAMS = DEF_NBEAMS,
  parameter int SCAL_BITS = DEF_SCAL_BITS,
  parameter int HOLDOFF = DEF_HOLDOFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NBEAMS-1:0] trigger_i,
  input  logic              period_i,
  output logic [NBEAMS-1:0] trig_o,
  output logic              overrun_o,
  beam_trigger_scaler_if.master rd
);
  localparam int IW = idx_bits(NBEAMS);
  logic [SCAL_BITS-1:0] live [NBEAMS];
  logic [SCAL_BITS-1:0] shadow_q [NBEAMS];
  logic [SCAL_BITS-1:0] shadow_d [NBEAMS];
  rd_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic overrun_q, overrun_d, dump, xfer, last;
  for (genvar g = 0; g < NBEAMS; g++) begin : g_beam
    beam_holdoff_counter #(.SCAL_BITS(SCAL_BITS), .HOLDOFF(HOLDOFF)) u_cnt (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .trigger_i(trigger_i[g]),
      .clear_i(period_i),
      .trig_o(trig_o[g]),
      .count_o(live[g])
    );
  end
  always_comb begin
    dump = state_q == DUMP;
    xfer = dump && rd.scal_ready_i;
    last = idx_q == IW'(NBEAMS - 1);
    overrun_d = overrun_q | (period_i & dump);
    shadow_d = (!dump && period_i) ? live : shadow_q;
    state_d = dump ? ((xfer && last) ? IDLE : DUMP) : (period_i ? DUMP : IDLE);
    idx_d = xfer ? (last ? '0 : IW'(idx_q + 1'b1)) : (dump ? idx_q : '0);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q <= '0;
      overrun_q <= 1'b0;
      shadow_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      overrun_q <= overrun_d;
      shadow_q <= shadow_d;
    end
  end
  assign rd.scal_valid_o = state_q == DUMP;
  assign rd.scal_data_o = shadow_q[idx_q];
  assign rd.scal_idx_o = idx_q;
  assign overrun_o = overrun_q;
endmodule

// File: tb/tb_beam_trigger_scaler.sv
// tb_beam_trigger_scaler: directed checks on holdoff, saturation, readout handshake, overrun and reset
module tb_beam_trigger_scaler;
  logic clk, rst;
  logic [1:0] trig_a, trig_b, trig_c, tro_a, tro_b, tro_c;
  logic per_a, per_b, per_c, ovr_a, ovr_b, ovr_c;
  int n_cmp, n_bad;
  beam_trigger_scaler_if #(.SCAL_BITS(16), .IW(1)) if_a ();
  beam_trigger_scaler_if #(.SCAL_BITS(16), .IW(1)) if_b ();
  beam_trigger_scaler_if #(.SCAL_BITS(4), .IW(1)) if_c ();
  beam_trigger_scaler #(.NBEAMS(2), .SCAL_BITS(16), .HOLDOFF(4)) u_a (
    .clk_i(clk), .rst_i(rst), .trigger_i(trig_a), .period_i(per_a), .trig_o(tro_a), .overrun_o(ovr_a), .rd(if_a)
  );
  beam_trigger_scaler #(.NBEAMS(2), .SCAL_BITS(16), .HOLDOFF(0)) u_b (
    .clk_i(clk), .rst_i(rst), .trigger_i(trig_b), .period_i(per_b), .trig_o(tro_b), .overrun_o(ovr_b), .rd(if_b)
  );
  beam_trigger_scaler #(.NBEAMS(2), .SCAL_BITS(4), .HOLDOFF(0)) u_c (
    .clk_i(clk), .rst_i(rst), .trigger_i(trig_c), .period_i(per_c), .trig_o(tro_c), .overrun_o(ovr_c), .rd(if_c)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    {trig_a, trig_b, trig_c, per_a, per_b, per_c} = '0;
    if_a.scal_ready_i = 1'b0;
    if_b.scal_ready_i = 1'b0;
    if_c.scal_ready_i = 1'b0;
    tick;
    tick;
    chk("rst_trig", 32'(tro_a), 0);
    chk("rst_valid", 32'(if_a.scal_valid_o), 0);
    chk("rst_data", 32'(if_a.scal_data_o), 0);
    chk("rst_idx", 32'(if_a.scal_idx_o), 0);
    chk("rst_ovr", 32'(ovr_a), 0);
    trig_a = 2'b11;
    per_a = 1'b1;
    tick;
    rst = 1'b0;
    trig_a = 2'b00;
    per_a = 1'b0;
    tick;
    chk("rst_ign_trig", 32'(tro_a), 0);
    chk("rst_ign_valid", 32'(if_a.scal_valid_o), 0);
    trig_a = 2'b01;
    for (int k = 1; k <= 12; k++) begin
      tick;
      if (k == 12) trig_a = 2'b00;
      chk($sformatf("hold4_c%0d", k), 32'(tro_a), (k == 1 || k == 6 || k == 11) ? 32'd1 : 32'd0);
    end
    tick;
    tick;
    per_a = 1'b1;
    if_a.scal_ready_i = 1'b1;
    tick;
    per_a = 1'b0;
    chk("hold4_valid", 32'(if_a.scal_valid_o), 1);
    chk("hold4_idx0", 32'(if_a.scal_idx_o), 0);
    chk("hold4_cnt0", 32'(if_a.scal_data_o), 3);
    tick;
    chk("hold4_idx1", 32'(if_a.scal_idx_o), 1);
    chk("hold4_cnt1", 32'(if_a.scal_data_o), 0);
    tick;
    chk("hold4_done", 32'(if_a.scal_valid_o), 0);
    trig_b = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      tick;
      chk($sformatf("h0_trig_c%0d", k), 32'(tro_b), 3);
    end
    trig_b = 2'b00;
    per_b = 1'b1;
    if_b.scal_ready_i = 1'b1;
    tick;
    per_b = 1'b0;
    chk("h0_valid0", 32'(if_b.scal_valid_o), 1);
    chk("h0_idx0", 32'(if_b.scal_idx_o), 0);
    chk("h0_data0", 32'(if_b.scal_data_o), 5);
    tick;
    chk("h0_valid1", 32'(if_b.scal_valid_o), 1);
    chk("h0_idx1", 32'(if_b.scal_idx_o), 1);
    chk("h0_data1", 32'(if_b.scal_data_o), 5);
    tick;
    chk("h0_done", 32'(if_b.scal_valid_o), 0);
    trig_c = 2'b10;
    for (int k = 0; k < 20; k++) tick;
    trig_c = 2'b00;
    per_c = 1'b1;
    if_c.scal_ready_i = 1'b1;
    tick;
    per_c = 1'b0;
    chk("sat_idx0", 32'(if_c.scal_data_o), 0);
    tick;
    chk("sat_idx", 32'(if_c.scal_idx_o), 1);
    chk("sat_data", 32'(if_c.scal_data_o), 15);
    tick;
    chk("sat_done", 32'(if_c.scal_valid_o), 0);
    trig_b = 2'b01;
    tick;
    tick;
    tick;
    trig_b = 2'b10;
    per_b = 1'b1;
    if_b.scal_ready_i = 1'b0;
    tick;
    trig_b = 2'b00;
    per_b = 1'b0;
    chk("ovr_pre", 32'(ovr_b), 0);
    for (int s = 0; s < 10; s++) begin
      chk($sformatf("stall_valid_%0d", s), 32'(if_b.scal_valid_o), 1);
      chk($sformatf("stall_idx_%0d", s), 32'(if_b.scal_idx_o), 0);
      chk($sformatf("stall_data_%0d", s), 32'(if_b.scal_data_o), 3);
      if (s == 4) per_b = 1'b1;
      tick;
      per_b = 1'b0;
    end
    chk("ovr_set", 32'(ovr_b), 1);
    if_b.scal_ready_i = 1'b1;
    tick;
    chk("stall_idx1", 32'(if_b.scal_idx_o), 1);
    chk("stall_data1", 32'(if_b.scal_data_o), 0);
    tick;
    chk("stall_done", 32'(if_b.scal_valid_o), 0);
    chk("ovr_sticky", 32'(ovr_b), 1);
    per_b = 1'b1;
    tick;
    per_b = 1'b0;
    chk("clr_data0", 32'(if_b.scal_data_o), 0);
    tick;
    chk("clr_data1", 32'(if_b.scal_data_o), 0);
    tick;
    trig_a = 2'b01;
    per_a = 1'b1;
    tick;
    trig_a = 2'b00;
    per_a = 1'b0;
    chk("coin_trig", 32'(tro_a), 1);
    chk("coin_shadow0", 32'(if_a.scal_data_o), 0);
    tick;
    tick;
    chk("coin_done", 32'(if_a.scal_valid_o), 0);
    per_a = 1'b1;
    tick;
    per_a = 1'b0;
    chk("coin_next0", 32'(if_a.scal_data_o), 1);
    tick;
    tick;
    trig_b = 2'b11;
    tick;
    tick;
    trig_b = 2'b00;
    per_b = 1'b1;
    tick;
    per_b = 1'b0;
    chk("mid_data0", 32'(if_b.scal_data_o), 2);
    tick;
    chk("mid_valid1", 32'(if_b.scal_valid_o), 1);
    chk("mid_idx1", 32'(if_b.scal_idx_o), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_valid", 32'(if_b.scal_valid_o), 0);
    chk("mid_rst_data", 32'(if_b.scal_data_o), 0);
    chk("mid_rst_idx", 32'(if_b.scal_idx_o), 0);
    chk("mid_rst_ovr", 32'(ovr_b), 0);
    chk("mid_rst_trig", 32'(tro_b), 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("mid_quiet_%0d", k), 32'(if_b.scal_valid_o), 0);
    end
    per_b = 1'b1;
    tick;
    per_b = 1'b0;
    chk("post_rst_valid", 32'(if_b.scal_valid_o), 1);
    chk("post_rst_data", 32'(if_b.scal_data_o), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
